nibble_deserializer_ce: RTL and testbench
=========================================

NIBBLE_DESERIALIZER_CE -- requirements
Module: nibble_deserializer_ce

Interface
REQ-001 The block SHALL have one parameter: STOP_CHECK, default 1, where 1 means a stop bit of 0 is flagged as a framing error and 0 means the stop-bit value is ignored.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port R, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port SIN, input, 1 bit: the serial data line, idle-high.
REQ-005 The block SHALL have port EN, input, 1 bit: the bit-sample strobe; SIN is sampled only on rising clk edges where EN=1.
REQ-006 The block SHALL have port D_OUT, output, 4 bits: the last correctly framed nibble, registered, driving the downstream register's D.
REQ-007 The block SHALL have port CE_OUT, output, 1 bit: a one-cycle load strobe driving the downstream register's CE.
REQ-008 The block SHALL have port FERR, output, 1 bit: a one-cycle framing-error pulse.
REQ-009 The block SHALL have port BUSY, output, 1 bit: high while a frame is in progress.
REQ-010 The block SHALL use one clock, clk, and an asynchronous, active-high reset, R.

Function
REQ-011 The frame format SHALL be: start bit (0), then 4 data bits LSB first, then a stop bit (1), with one bit per EN sample.
REQ-012 The FSM SHALL have exactly the states IDLE, DATA and STOP, plus a 2-bit bit counter and a 4-bit shift register.
REQ-013 IDLE: on an EN sample with SIN=0, the FSM SHALL go to DATA with counter=0; on an EN sample with SIN=1, or with EN=0, it SHALL stay in IDLE.
REQ-014 DATA: on each EN sample, SIN SHALL be written to shift-register bit [counter] and the counter SHALL increment; the sample taken at counter=3 SHALL move the FSM to STOP.
REQ-015 STOP, valid frame: on an EN sample with SIN=1 (or any SIN when STOP_CHECK=0), D_OUT SHALL load the shift register, CE_OUT SHALL be 1 for the following cycle, and the FSM SHALL go to IDLE.
REQ-016 STOP, bad frame: on an EN sample with SIN=0 and STOP_CHECK=1, FERR SHALL be 1 for the following cycle, D_OUT SHALL stay unchanged, CE_OUT SHALL stay 0, and the FSM SHALL go to IDLE.
REQ-017 Latency: D_OUT and CE_OUT SHALL update on the same edge that samples the stop bit, so that D_OUT is already stable when CE_OUT is high.
REQ-018 CE_OUT and FERR SHALL never both be 1, and each SHALL be high for exactly one clk cycle per frame regardless of EN.
REQ-019 EN=0 cycles SHALL freeze the state, counter and shift register; any number of stall cycles between samples SHALL be legal.
REQ-020 Back-to-back frames: a start bit on the EN sample immediately after the stop-bit sample SHALL be accepted, with no dead sample.
REQ-021 BUSY SHALL be 1 exactly while the state is DATA or STOP (registered state decode).
REQ-022 D_OUT SHALL hold its value indefinitely between valid frames.
REQ-023 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-024 While R=1, independent of clk, the block SHALL force: state=IDLE, counter=0, shift register=0000, D_OUT=0000, CE_OUT=0, FERR=0, BUSY=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no CE_OUT or FERR pulse, and the first clk edge after R falls SHALL behave as IDLE.
REQ-026 R SHALL take priority over EN and SIN on every edge.

Verification
REQ-027 Valid frame: EN=1 every cycle, SIN = 0,1,0,1,1,1 -> D_OUT=4'b1101 and CE_OUT=1 for one cycle after the 6th sample; FERR=0.
REQ-028 Framing error: SIN = 0,1,1,1,1,0 with STOP_CHECK=1 -> FERR=1 for one cycle, CE_OUT=0, D_OUT keeps its prior value (0000 after reset); repeating with STOP_CHECK=0 -> D_OUT=4'b1111 and CE_OUT=1.
REQ-029 Stalls: the frame 0,0,1,1,0,1 with 3 EN=0 cycles inserted between every sample -> D_OUT=4'b0110, exactly one CE_OUT pulse, and BUSY high from the start-bit sample through the stop-bit sample.
REQ-030 Back-to-back: frame 0,1,0,0,0,1 immediately followed by frame 0,0,0,0,1,1 -> CE_OUT pulses 6 cycles apart, with D_OUT=0001 then 1000.
REQ-031 Reset mid-frame: assert R asynchronously (between edges) after the 3rd data bit -> all outputs go to 0 immediately with no CE_OUT; the next valid frame 0,1,1,0,0,1 -> D_OUT=4'b0011.
REQ-032 Idle noise: SIN=1 with EN=1 for 20 cycles -> BUSY=0, CE_OUT=0, FERR=0 throughout.

Source files
------------

// File: rtl/nibble_deserializer_ce.sv
// Serial-to-parallel receiver for start/4-data/stop nibble frames sampled on EN.
// Drives a downstream register directly: D_OUT is stable whenever CE_OUT is high.
module nibble_deserializer_ce #(
  parameter bit STOP_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       R,
  input  logic       SIN,
  input  logic       EN,
  output logic [3:0] D_OUT,
  output logic       CE_OUT,
  output logic       FERR,
  output logic       BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0] state;
  logic [1:0] bit_cnt;
  logic [3:0] shift_reg;

  // Strobes default low every cycle so each pulse lasts exactly one clk, whatever EN does.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state     <= IDLE;
      bit_cnt   <= 2'd0;
      shift_reg <= 4'd0;
      D_OUT     <= 4'd0;
      CE_OUT    <= 1'b0;
      FERR      <= 1'b0;
    end else begin
      CE_OUT <= 1'b0;
      FERR   <= 1'b0;
      if (EN) begin
        case (state)
          IDLE: begin
            if (!SIN) begin
              state   <= DATA;
              bit_cnt <= 2'd0;
            end
          end
          DATA: begin
            shift_reg[bit_cnt] <= SIN;
            bit_cnt            <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              state <= STOP;
            end
          end
          STOP: begin
            if (SIN || !STOP_CHECK) begin
              D_OUT  <= shift_reg;
              CE_OUT <= 1'b1;
            end else begin
              FERR <= 1'b1;
            end
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Decoded from the state register only, so no input reaches BUSY combinationally.
  assign BUSY = (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_nibble_deserializer_ce.sv
// Scoreboard bench for nibble_deserializer_ce: one instance with stop checking, one without.
// Expected pulses are queued when the stop bit is driven and popped when a DUT pulses.
module tb_nibble_deserializer_ce;

  typedef struct {
    logic       is_ferr;
    logic [3:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       SIN = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] d_a, d_b;
  logic       ce_a, ce_b, ferr_a, ferr_b, busy_a, busy_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int ce_cycles[$];
  logic [3:0] last_a = 4'd0;

  nibble_deserializer_ce #(.STOP_CHECK(1'b1)) dut_a (
    .clk(clk), .R(R), .SIN(SIN), .EN(EN),
    .D_OUT(d_a), .CE_OUT(ce_a), .FERR(ferr_a), .BUSY(busy_a)
  );

  nibble_deserializer_ce #(.STOP_CHECK(1'b0)) dut_b (
    .clk(clk), .R(R), .SIN(SIN), .EN(EN),
    .D_OUT(d_b), .CE_OUT(ce_b), .FERR(ferr_b), .BUSY(busy_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one clk cycle of inputs; the following rising edge samples them.
  task automatic applyStimulus(input logic s, input logic e);
    @(negedge clk);
    SIN = s;
    EN  = e;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
  endtask

  // seq[0] is the first SIN sample (start bit), seq[5] the stop bit.
  task automatic sendFrame(input logic [0:5] seq, input int stalls, input bit check_busy);
    logic [3:0] nib;
    exp_t e;
    nib = {seq[4], seq[3], seq[2], seq[1]};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        if (seq[5]) begin
          e.is_ferr = 1'b0; e.data = nib; last_a = nib;
        end else begin
          e.is_ferr = 1'b1; e.data = last_a;
        end
        q_a.push_back(e);
        e.is_ferr = 1'b0; e.data = nib;
        q_b.push_back(e);
      end
      applyStimulus(seq[i], 1'b1);
      for (int k = 0; k < stalls; k++) begin
        applyStimulus(1'($urandom_range(1)), 1'b0);
        if (check_busy && k == 0)
          checkOutput($sformatf("busy_after_sample%0d", i), {31'd0, busy_a}, (i < 5) ? 32'd1 : 32'd0);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (ce_a || ferr_a) begin
      if (q_a.size() == 0) begin
        checkOutput("a_unexpected_pulse", {30'd0, ce_a, ferr_a}, 32'd0);
      end else begin
        ea = q_a.pop_front();
        checkOutput("a_kind", {30'd0, ce_a, ferr_a}, ea.is_ferr ? 32'd1 : 32'd2);
        checkOutput("a_dout", {28'd0, d_a}, {28'd0, ea.data});
        if (ce_a) ce_cycles.push_back(cyc);
      end
    end
    if (ce_b || ferr_b) begin
      if (q_b.size() == 0) begin
        checkOutput("b_unexpected_pulse", {30'd0, ce_b, ferr_b}, 32'd0);
      end else begin
        eb = q_b.pop_front();
        checkOutput("b_kind", {30'd0, ce_b, ferr_b}, eb.is_ferr ? 32'd1 : 32'd2);
        checkOutput("b_dout", {28'd0, d_b}, {28'd0, eb.data});
      end
    end
  end

  initial begin
    // Reset state
    #12;
    checkOutput("rst_a", {25'd0, d_a, ce_a, ferr_a, busy_a}, 32'd0);
    checkOutput("rst_b", {25'd0, d_b, ce_b, ferr_b, busy_b}, 32'd0);
    @(negedge clk);
    R = 1'b0;
    idleCycles(2);

    // Idle noise
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (i > 0) checkOutput("noise_busy", {30'd0, busy_a, busy_b}, 32'd0);
    end
    idleCycles(2);

    // Framing error first, so dut_a must keep its reset value 0000
    sendFrame(6'b011110, 0, 1'b0);
    idleCycles(3);
    checkOutput("ferr_hold_a", {28'd0, d_a}, 32'h0);
    checkOutput("nocheck_b", {28'd0, d_b}, 32'hF);

    // Valid frame -> 1101
    sendFrame(6'b010111, 0, 1'b0);
    idleCycles(3);
    checkOutput("valid_a", {28'd0, d_a}, 32'hD);

    // Stalled frame -> 0110, BUSY from start sample through stop sample
    sendFrame(6'b001101, 3, 1'b1);
    idleCycles(3);
    checkOutput("stall_a", {28'd0, d_a}, 32'h6);

    // Back-to-back frames -> 0001 then 1000, CE pulses 6 cycles apart
    ce_cycles.delete();
    sendFrame(6'b010001, 0, 1'b0);
    sendFrame(6'b000011, 0, 1'b0);
    idleCycles(3);
    checkOutput("b2b_count", ce_cycles.size(), 32'd2);
    if (ce_cycles.size() == 2)
      checkOutput("b2b_spacing", ce_cycles[1] - ce_cycles[0], 32'd6);
    checkOutput("b2b_last", {28'd0, d_a}, 32'h8);

    // Reset asynchronously after the 3rd data bit
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    EN = 1'b0;
    #2;
    R = 1'b1;
    #1;
    checkOutput("midrst_a", {25'd0, d_a, ce_a, ferr_a, busy_a}, 32'd0);
    checkOutput("midrst_b", {25'd0, d_b, ce_b, ferr_b, busy_b}, 32'd0);
    last_a = 4'd0;
    idleCycles(2);
    R = 1'b0;
    sendFrame(6'b011001, 0, 1'b0);
    idleCycles(3);
    checkOutput("after_rst_a", {28'd0, d_a}, 32'h3);
    checkOutput("after_rst_b", {28'd0, d_b}, 32'h3);

    checkOutput("sb_a_drained", q_a.size(), 32'd0);
    checkOutput("sb_b_drained", q_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
